ddr_ui_arbiter: RTL and testbench
=================================

DDR_UI_ARBITER -- requirements
Module: ddr_ui_arbiter

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- NCHAN, 2: client channels.
- ADDR_W, 27: UI address width.
- DATA_W, 256: UI data width; mask width MW = DATA_W/8.
- RDQ_DEPTH, 16: max outstanding reads; power of 2, at least 2.
REQ-002 The block SHALL have one clock, user_clock; reset user_reset is asynchronous, active-high. Ports, one per line: name, direction, width, meaning:
- user_clock  in  1  sole clock; all logic on rising edge.
- user_reset  in  1  asynchronous active-high reset.
- init_done  in  1  memory calibration complete.
- req_valid  in  NCHAN  per-channel request valid.
- req_write  in  NCHAN  1 = write, 0 = read.
- req_addr  in  NCHAN*ADDR_W  per-channel address; channel i at slice i.
- req_data  in  NCHAN*DATA_W  per-channel write data.
- req_mask  in  NCHAN*MW  per-channel byte mask; 1 = byte not written.
- req_ready  out  NCHAN  request accepted when valid and ready are both high.
- rsp_valid  out  NCHAN  one-hot read-data strobe; no backpressure.
- rsp_data  out  DATA_W  read data shared by all channels.
- app_en, app_cmd, app_addr  out  1, 3, ADDR_W  UI command (cmd 000 = write, 001 = read).
- app_rdy  in  1  UI command accept.
- app_wdf_wren, app_wdf_end  out  1, 1  UI write strobe; end always equals wren.
- app_wdf_data, app_wdf_mask  out  DATA_W, MW  UI write data and mask.
- app_wdf_rdy  in  1  UI write-data accept.
- app_rd_data, app_rd_data_valid  in  DATA_W, 1  UI read return.
- tag_err  out  1  sticky flag: read data arrived with no outstanding read.
- perf_rd_cnt, perf_wr_cnt  out  32, 32  issued read and write command counts.

Function
REQ-003 The block SHALL hold one command register (CR: valid, cmd, addr, data, mask, and channel id); app_en = CR.valid; app_wdf_wren = CR.valid and CR is a write.
REQ-004 A read in CR SHALL retire when app_rdy = 1; a write in CR SHALL retire only when app_rdy and app_wdf_rdy are both 1 in the same cycle.
REQ-005 CR SHALL be loadable when it is empty or retiring in that cycle; a client request accepted in cycle N SHALL appear on app_en in cycle N+1, giving back-to-back throughput of 1 per cycle.
REQ-006 Arbitration SHALL be round-robin: grant goes to the first channel with req_valid set, searching from pointer P upward with wrap. req_ready is asserted only for the granted channel, and only when CR is loadable, init_done = 1, and, for a read, the outstanding count is less than RDQ_DEPTH.
REQ-007 P SHALL advance to (granted + 1) mod NCHAN only on acceptance; if nothing is accepted, P SHALL be held.
REQ-008 On read acceptance, the channel id SHALL be pushed into a tag FIFO of depth RDQ_DEPTH; the outstanding count SHALL increase on push and decrease on pop, and stay unchanged when both happen in the same cycle.
REQ-009 When app_rd_data_valid = 1, the block SHALL pop a tag; in cycle M+1, rsp_valid[tag] = 1 and rsp_data = app_rd_data registered, so returns are in order.
REQ-010 When app_rd_data_valid = 1 and the tag FIFO is empty, the block SHALL set tag_err, assert no rsp_valid, and leave the count at 0.
REQ-011 A write SHALL never block on the tag FIFO; when reads are blocked because the FIFO is full, a write from another channel SHALL still be granted.
REQ-012 When init_done = 0, req_ready SHALL be all 0; a CR entry already loaded SHALL still be presented.

Reset
REQ-013 While user_reset = 1: CR.valid = 0, app_en = app_wdf_wren = app_wdf_end = 0, req_ready = 0, rsp_valid = 0, rsp_data = 0, P = 0, tag FIFO empty, count = 0, tag_err = 0, perf counters = 0.
REQ-014 A reset in mid-operation SHALL discard CR contents and outstanding tags; read data arriving after reset SHALL set tag_err.

Configuration
REQ-015 Macro DDR_UI_ARBITER_PERF_EN: when defined, perf_rd_cnt and perf_wr_cnt SHALL count retired reads and writes, wrapping at 2^32; when undefined, both SHALL be constant 0 and the counters SHALL not be synthesised.

Verification
REQ-016 Hold init_done = 0 with ch0 read valid -> req_ready = 0. Raise init_done -> app_en = 1, app_cmd = 001 one cycle after acceptance.
REQ-017 ch0 and ch1 both valid continuously, app_rdy = 1 -> grants alternate 0,1,0,1 and app_en stays high every cycle.
REQ-018 Write with app_rdy = 1, app_wdf_rdy = 0 for 3 cycles -> CR held with app_en and app_wdf_wren high, req_ready = 0, then retired in the cycle app_wdf_rdy = 1.
REQ-019 With RDQ_DEPTH = 16, issue 16 reads on ch1 with no returns -> 17th read stalls while a ch0 write is still granted; return 16 data words -> rsp_valid[1] = 1 sixteen times, in order.
REQ-020 app_rd_data_valid pulse with the tag FIFO empty -> tag_err = 1 and no rsp_valid. Assert user_reset for 1 cycle with 4 reads outstanding -> count = 0, app_en = 0 asynchronously.

Source files
------------

// File: rtl/ddr_ui_arbiter.sv
// ddr_ui_arbiter: round-robin arbiter from NCHAN client channels onto a single
// DDR user-interface command/write-data port, with an in-order tag FIFO that
// routes read data back to the channel that issued the read.
// Optional feature macro: DDR_UI_ARBITER_PERF_EN enables the retired read/write
// command counters; without it perf_rd_cnt/perf_wr_cnt are tied to zero.
module ddr_ui_arbiter #(
  parameter int NCHAN     = 2,
  parameter int ADDR_W    = 27,
  parameter int DATA_W    = 256,
  parameter int RDQ_DEPTH = 16
) (
  input  logic                        user_clock,
  input  logic                        user_reset,
  input  logic                        init_done,
  input  logic [NCHAN-1:0]            req_valid,
  input  logic [NCHAN-1:0]            req_write,
  input  logic [NCHAN*ADDR_W-1:0]     req_addr,
  input  logic [NCHAN*DATA_W-1:0]     req_data,
  input  logic [NCHAN*(DATA_W/8)-1:0] req_mask,
  output logic [NCHAN-1:0]            req_ready,
  output logic [NCHAN-1:0]            rsp_valid,
  output logic [DATA_W-1:0]           rsp_data,
  output logic                        app_en,
  output logic [2:0]                  app_cmd,
  output logic [ADDR_W-1:0]           app_addr,
  input  logic                        app_rdy,
  output logic                        app_wdf_wren,
  output logic                        app_wdf_end,
  output logic [DATA_W-1:0]           app_wdf_data,
  output logic [DATA_W/8-1:0]         app_wdf_mask,
  input  logic                        app_wdf_rdy,
  input  logic [DATA_W-1:0]           app_rd_data,
  input  logic                        app_rd_data_valid,
  output logic                        tag_err,
  output logic [31:0]                 perf_rd_cnt,
  output logic [31:0]                 perf_wr_cnt
);

  localparam int MW  = DATA_W / 8;
  localparam int CHW = (NCHAN > 1) ? $clog2(NCHAN) : 1;
  localparam int AW  = $clog2(RDQ_DEPTH);
  localparam int CW  = AW + 1;

  // Command register
  logic              crValid_q;
  logic              crWrite_q;
  logic [ADDR_W-1:0] crAddr_q;
  logic [DATA_W-1:0] crData_q;
  logic [MW-1:0]     crMask_q;
  logic [CHW-1:0]    crChan_q;

  // Arbitration state
  logic [CHW-1:0]    ptr_q, ptr_d;
  logic [NCHAN-1:0]  eligible;
  logic              found;
  logic [CHW-1:0]    grant;
  logic              retire, loadable, accept, push, pop, rdRoom;

  // Tag FIFO
  logic [CHW-1:0]    tagMem_q [RDQ_DEPTH];
  logic [AW-1:0]     wrPtr_q, rdPtr_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CHW-1:0]    popTag;

  // Read response
  logic [NCHAN-1:0]  rspValid_q, rspValid_d;
  logic [DATA_W-1:0] rspData_q;
  logic              tagErr_q, tagErr_d;

  assign retire   = crValid_q & app_rdy & (~crWrite_q | app_wdf_rdy);
  assign loadable = ~crValid_q | retire;
  assign rdRoom   = (cnt_q < CW'(RDQ_DEPTH));
  assign eligible = req_valid & (req_write | {NCHAN{rdRoom}});
  assign popTag   = tagMem_q[rdPtr_q];

  // Round-robin search from the pointer; reads are masked out while the tag FIFO is full
  always_comb begin
    found = 1'b0;
    grant = '0;
    for (int k = 0; k < NCHAN; k++) begin
      if (!found && eligible[(int'(ptr_q) + k) % NCHAN]) begin
        found = 1'b1;
        grant = CHW'((int'(ptr_q) + k) % NCHAN);
      end
    end
  end

  // Acceptance, FIFO push/pop, pointer advance and outstanding-count update
  always_comb begin
    accept    = found & loadable & init_done & ~user_reset;
    req_ready = accept ? (NCHAN'(1) << grant) : '0;
    push      = accept & ~req_write[grant];
    pop       = app_rd_data_valid & (cnt_q != '0);
    ptr_d     = ptr_q;
    if (accept) begin
      if (int'(grant) == NCHAN - 1) ptr_d = '0;
      else                          ptr_d = grant + CHW'(1);
    end
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (pop && !push) cnt_d = cnt_q - CW'(1);
    rspValid_d = pop ? (NCHAN'(1) << popTag) : '0;
    tagErr_d   = tagErr_q | (app_rd_data_valid & (cnt_q == '0));
  end

  // Command register: load on acceptance, clear when the UI takes the command
  always_ff @(posedge user_clock or posedge user_reset) begin
    if (user_reset) begin
      crValid_q <= 1'b0;
      crWrite_q <= 1'b0;
      crAddr_q  <= '0;
      crData_q  <= '0;
      crMask_q  <= '0;
      crChan_q  <= '0;
    end else if (accept) begin
      crValid_q <= 1'b1;
      crWrite_q <= req_write[grant];
      crAddr_q  <= req_addr[int'(grant)*ADDR_W +: ADDR_W];
      crData_q  <= req_data[int'(grant)*DATA_W +: DATA_W];
      crMask_q  <= req_mask[int'(grant)*MW +: MW];
      crChan_q  <= grant;
    end else if (retire) begin
      crValid_q <= 1'b0;
    end
  end

  // Arbitration pointer, tag FIFO pointers and outstanding count
  always_ff @(posedge user_clock or posedge user_reset) begin
    if (user_reset) begin
      ptr_q   <= '0;
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      cnt_q   <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      if (push) wrPtr_q <= wrPtr_q + AW'(1);
      if (pop)  rdPtr_q <= rdPtr_q + AW'(1);
    end
  end

  // Tag storage needs no reset; the pointers define which entries are live
  always_ff @(posedge user_clock) begin
    if (push) tagMem_q[wrPtr_q] <= grant;
  end

  // Registered read response and sticky orphan-data flag
  always_ff @(posedge user_clock or posedge user_reset) begin
    if (user_reset) begin
      rspValid_q <= '0;
      rspData_q  <= '0;
      tagErr_q   <= 1'b0;
    end else begin
      rspValid_q <= rspValid_d;
      tagErr_q   <= tagErr_d;
      if (app_rd_data_valid) rspData_q <= app_rd_data;
    end
  end

  assign app_en       = crValid_q;
  assign app_cmd      = crWrite_q ? 3'b000 : 3'b001;
  assign app_addr     = crAddr_q;
  assign app_wdf_wren = crValid_q & crWrite_q;
  assign app_wdf_end  = crValid_q & crWrite_q;
  assign app_wdf_data = crData_q;
  assign app_wdf_mask = crMask_q;
  assign rsp_valid    = rspValid_q;
  assign rsp_data     = rspData_q;
  assign tag_err      = tagErr_q;

`ifdef DDR_UI_ARBITER_PERF_EN
  logic [31:0] perfRd_q, perfWr_q;

  // Count commands as the UI retires them; wraps naturally at 2^32
  always_ff @(posedge user_clock or posedge user_reset) begin
    if (user_reset) begin
      perfRd_q <= '0;
      perfWr_q <= '0;
    end else if (retire) begin
      if (crWrite_q) perfWr_q <= perfWr_q + 32'd1;
      else           perfRd_q <= perfRd_q + 32'd1;
    end
  end

  assign perf_rd_cnt = perfRd_q;
  assign perf_wr_cnt = perfWr_q;
`else
  assign perf_rd_cnt = '0;
  assign perf_wr_cnt = '0;
`endif

  // The channel id travels with the command for debug visibility only
  logic unusedChan;
  assign unusedChan = ^crChan_q;

endmodule

// File: tb/tb_ddr_ui_arbiter.sv
// Testbench for ddr_ui_arbiter: table-driven arbitration/command vectors plus
// hand-written sequences for tag-FIFO full, read return ordering, orphan read
// data and mid-operation reset. Read responses are checked against a queue of
// expected {channel, data} records filled when the bench drives read data.
module tb_ddr_ui_arbiter;

  localparam int NCHAN  = 2;
  localparam int ADDR_W = 27;
  localparam int DATA_W = 256;
  localparam int MW     = DATA_W / 8;

  logic                    user_clock = 1'b0;
  logic                    user_reset;
  logic                    init_done;
  logic [NCHAN-1:0]        req_valid;
  logic [NCHAN-1:0]        req_write;
  logic [NCHAN*ADDR_W-1:0] req_addr;
  logic [NCHAN*DATA_W-1:0] req_data;
  logic [NCHAN*MW-1:0]     req_mask;
  logic [NCHAN-1:0]        req_ready;
  logic [NCHAN-1:0]        rsp_valid;
  logic [DATA_W-1:0]       rsp_data;
  logic                    app_en;
  logic [2:0]              app_cmd;
  logic [ADDR_W-1:0]       app_addr;
  logic                    app_rdy;
  logic                    app_wdf_wren;
  logic                    app_wdf_end;
  logic [DATA_W-1:0]       app_wdf_data;
  logic [MW-1:0]           app_wdf_mask;
  logic                    app_wdf_rdy;
  logic [DATA_W-1:0]       app_rd_data;
  logic                    app_rd_data_valid;
  logic                    tag_err;
  logic [31:0]             perf_rd_cnt;
  logic [31:0]             perf_wr_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic              init;
    logic [1:0]        valid;
    logic [1:0]        write;
    logic              appRdy;
    logic              wdfRdy;
    logic [1:0]        expReady;
    logic              expEn;
    logic [2:0]        expCmd;
    logic [ADDR_W-1:0] expAddr;
  } vec_t;

  typedef struct {
    logic [1:0]        chanHot;
    logic [DATA_W-1:0] data;
  } rsp_t;

  vec_t vecs[16];
  rsp_t expQ[$];
  int   readModel[$];
  int   expRd = 0;
  int   expWr = 0;

  logic [ADDR_W-1:0] addr0 = 27'h100;
  logic [ADDR_W-1:0] addr1 = 27'h200;
  logic [DATA_W-1:0] data0 = {8{32'hA5A5_0000}};
  logic [DATA_W-1:0] data1 = {8{32'h5A5A_1111}};
  logic [MW-1:0]     mask0 = 32'h0000_00FF;
  logic [MW-1:0]     mask1 = 32'hFF00_0000;

  ddr_ui_arbiter #(.NCHAN(NCHAN), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RDQ_DEPTH(16)) dut (
    .user_clock(user_clock), .user_reset(user_reset), .init_done(init_done),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_data(req_data), .req_mask(req_mask), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr), .app_rdy(app_rdy),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .tag_err(tag_err), .perf_rd_cnt(perf_rd_cnt), .perf_wr_cnt(perf_wr_cnt)
  );

  // 100 MHz user clock
  always #5 user_clock = ~user_clock;

  // Give up if the run ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, time=%0t required=finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [DATA_W-1:0] actual,
                             input logic [DATA_W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic init, input logic [1:0] valid, input logic [1:0] write,
                               input logic appRdy, input logic wdfRdy);
    init_done   = init;
    req_valid   = valid;
    req_write   = write;
    app_rdy     = appRdy;
    app_wdf_rdy = wdfRdy;
  endtask

  task automatic nextCycle();
    @(posedge user_clock);
    #1;
  endtask

  // Drive one read-data beat and predict which channel it belongs to
  task automatic applyReturn(input logic [DATA_W-1:0] d);
    rsp_t e;
    int   ch;
    app_rd_data_valid = 1'b1;
    app_rd_data       = d;
    if (readModel.size() > 0) begin
      ch        = readModel.pop_front();
      e.chanHot = 2'b01 << ch;
      e.data    = d;
      expQ.push_back(e);
    end
    nextCycle();
    app_rd_data_valid = 1'b0;
  endtask

  // Response monitor: every rsp_valid strobe must match the oldest expected return
  always @(negedge user_clock) begin
    if (rsp_valid !== '0) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_rsp: actual rsp_valid=%0b required=0", rsp_valid);
      end else begin
        rsp_t e;
        e = expQ.pop_front();
        checkOutput("rsp_valid", DATA_W'(rsp_valid), DATA_W'(e.chanHot));
        checkOutput("rsp_data", rsp_data, e.data);
      end
    end
  end

  initial begin
    // Arbitration and command-register vectors, one row per cycle
    vecs[0]  = '{1'b0, 2'b01, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 3'b000, 27'h0};
    vecs[1]  = '{1'b0, 2'b01, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 3'b000, 27'h0};
    vecs[2]  = '{1'b1, 2'b01, 2'b00, 1'b1, 1'b1, 2'b01, 1'b1, 3'b001, 27'h100};
    vecs[3]  = '{1'b1, 2'b11, 2'b00, 1'b1, 1'b1, 2'b10, 1'b1, 3'b001, 27'h200};
    vecs[4]  = '{1'b1, 2'b11, 2'b00, 1'b1, 1'b1, 2'b01, 1'b1, 3'b001, 27'h100};
    vecs[5]  = '{1'b1, 2'b11, 2'b00, 1'b1, 1'b1, 2'b10, 1'b1, 3'b001, 27'h200};
    vecs[6]  = '{1'b1, 2'b00, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 3'b000, 27'h0};
    vecs[7]  = '{1'b1, 2'b01, 2'b01, 1'b1, 1'b1, 2'b01, 1'b1, 3'b000, 27'h100};
    vecs[8]  = '{1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 3'b000, 27'h100};
    vecs[9]  = '{1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 3'b000, 27'h100};
    vecs[10] = '{1'b1, 2'b10, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 3'b000, 27'h100};
    vecs[11] = '{1'b1, 2'b10, 2'b00, 1'b0, 1'b1, 2'b00, 1'b1, 3'b000, 27'h100};
    vecs[12] = '{1'b1, 2'b10, 2'b00, 1'b1, 1'b1, 2'b10, 1'b1, 3'b001, 27'h200};
    vecs[13] = '{1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 1'b1, 3'b001, 27'h200};
    vecs[14] = '{1'b0, 2'b01, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 3'b000, 27'h0};
    vecs[15] = '{1'b1, 2'b00, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 3'b000, 27'h0};

    req_addr          = {addr1, addr0};
    req_data          = {data1, data0};
    req_mask          = {mask1, mask0};
    app_rd_data       = '0;
    app_rd_data_valid = 1'b0;
    user_reset        = 1'b1;
    applyStimulus(1'b1, 2'b01, 2'b00, 1'b1, 1'b1);

    // Reset state with a request pending
    repeat (2) nextCycle();
    checkOutput("reset_app_en", DATA_W'(app_en), '0);
    checkOutput("reset_wdf_wren", DATA_W'(app_wdf_wren), '0);
    checkOutput("reset_req_ready", DATA_W'(req_ready), '0);
    checkOutput("reset_rsp_valid", DATA_W'(rsp_valid), '0);
    checkOutput("reset_rsp_data", rsp_data, '0);
    checkOutput("reset_tag_err", DATA_W'(tag_err), '0);
    checkOutput("reset_perf_rd", DATA_W'(perf_rd_cnt), '0);
    checkOutput("reset_perf_wr", DATA_W'(perf_wr_cnt), '0);
    user_reset = 1'b0;
    applyStimulus(1'b1, 2'b00, 2'b00, 1'b1, 1'b1);
    nextCycle();

    // Table vectors: req_ready in the cycle, command register after the edge
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].init, vecs[i].valid, vecs[i].write, vecs[i].appRdy, vecs[i].wdfRdy);
      #1;
      checkOutput($sformatf("vec%0d_req_ready", i), DATA_W'(req_ready), DATA_W'(vecs[i].expReady));
      for (int c = 0; c < NCHAN; c++) begin
        if (vecs[i].expReady[c]) begin
          if (vecs[i].write[c]) expWr++;
          else begin
            expRd++;
            readModel.push_back(c);
          end
        end
      end
      nextCycle();
      checkOutput($sformatf("vec%0d_app_en", i), DATA_W'(app_en), DATA_W'(vecs[i].expEn));
      checkOutput($sformatf("vec%0d_wdf_wren", i), DATA_W'(app_wdf_wren),
                  DATA_W'(vecs[i].expEn && vecs[i].expCmd == 3'b000));
      checkOutput($sformatf("vec%0d_wdf_end", i), DATA_W'(app_wdf_end),
                  DATA_W'(vecs[i].expEn && vecs[i].expCmd == 3'b000));
      if (vecs[i].expEn) begin
        checkOutput($sformatf("vec%0d_app_cmd", i), DATA_W'(app_cmd), DATA_W'(vecs[i].expCmd));
        checkOutput($sformatf("vec%0d_app_addr", i), DATA_W'(app_addr), DATA_W'(vecs[i].expAddr));
        if (vecs[i].expCmd == 3'b000) begin
          checkOutput($sformatf("vec%0d_wdf_data", i), app_wdf_data, data0);
          checkOutput($sformatf("vec%0d_wdf_mask", i), DATA_W'(app_wdf_mask), DATA_W'(mask0));
        end
      end
    end

    // Return the reads issued by the table; expected order 0,1,0,1,1
    applyStimulus(1'b1, 2'b00, 2'b00, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) applyReturn({8{32'hC000_0000 + 32'(i)}});
    repeat (2) nextCycle();

    // Fill the tag FIFO with sixteen ch1 reads
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 2'b10, 2'b00, 1'b1, 1'b1);
      #1;
      checkOutput($sformatf("fill%0d_req_ready", i), DATA_W'(req_ready), DATA_W'(2'b10));
      expRd++;
      readModel.push_back(1);
      nextCycle();
    end
    // Seventeenth read blocked, ch0 write still granted
    applyStimulus(1'b1, 2'b11, 2'b01, 1'b1, 1'b1);
    #1;
    checkOutput("full_write_granted", DATA_W'(req_ready), DATA_W'(2'b01));
    expWr++;
    nextCycle();
    checkOutput("full_write_cmd", DATA_W'(app_cmd), DATA_W'(3'b000));
    applyStimulus(1'b1, 2'b10, 2'b00, 1'b1, 1'b1);
    #1;
    checkOutput("full_read_stalled", DATA_W'(req_ready), '0);
    nextCycle();
    applyStimulus(1'b1, 2'b00, 2'b00, 1'b1, 1'b1);
    nextCycle();
    checkOutput("full_drained_app_en", DATA_W'(app_en), '0);

    // Sixteen returns, all for ch1, in order
    for (int i = 0; i < 16; i++) applyReturn({8{32'hD000_0000 + 32'(i)}});
    repeat (2) nextCycle();

    // Orphan read data
    applyReturn({8{32'hEEEE_EEEE}});
    checkOutput("orphan_tag_err", DATA_W'(tag_err), DATA_W'(1'b1));
    checkOutput("orphan_no_rsp", DATA_W'(rsp_valid), '0);
    nextCycle();

`ifdef DDR_UI_ARBITER_PERF_EN
    checkOutput("perf_rd_cnt", DATA_W'(perf_rd_cnt), DATA_W'(expRd));
    checkOutput("perf_wr_cnt", DATA_W'(perf_wr_cnt), DATA_W'(expWr));
`else
    checkOutput("perf_rd_cnt", DATA_W'(perf_rd_cnt), '0);
    checkOutput("perf_wr_cnt", DATA_W'(perf_wr_cnt), '0);
`endif

    // Four outstanding reads, last one held in the command register
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 2'b01, 2'b00, 1'b1, 1'b1);
      #1;
      checkOutput($sformatf("prereset%0d_req_ready", i), DATA_W'(req_ready), DATA_W'(2'b01));
      readModel.push_back(0);
      nextCycle();
    end
    applyStimulus(1'b1, 2'b00, 2'b00, 1'b0, 1'b1);
    #1;
    checkOutput("prereset_app_en", DATA_W'(app_en), DATA_W'(1'b1));
    req_valid = 2'b01;
    #1;
    user_reset = 1'b1;
    #1;
    checkOutput("async_reset_app_en", DATA_W'(app_en), '0);
    checkOutput("async_reset_req_ready", DATA_W'(req_ready), '0);
    checkOutput("async_reset_tag_err", DATA_W'(tag_err), '0);
    readModel.delete();
    nextCycle();
    user_reset = 1'b0;
    applyStimulus(1'b1, 2'b00, 2'b00, 1'b1, 1'b1);
    nextCycle();
    checkOutput("postreset_app_en", DATA_W'(app_en), '0);
    checkOutput("postreset_perf_rd", DATA_W'(perf_rd_cnt), '0);

    // Stale read data after reset finds no tag
    applyReturn({8{32'hBBBB_0000}});
    checkOutput("postreset_tag_err", DATA_W'(tag_err), DATA_W'(1'b1));
    checkOutput("postreset_no_rsp", DATA_W'(rsp_valid), '0);
    repeat (3) nextCycle();

    checkOutput("expq_empty", DATA_W'(expQ.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
